// File: rtl/regread_arbiter4_pkg.sv
// Shared types and helpers for the four-way register-file read arbiter.
// Index/one-hot conversions are shared by the picker and the top-level decode.
package regread_arbiter4_pkg;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = 2;

  typedef enum logic [IDX_W-1:0] {
    REQ_FETCH  = 2'd0,
    REQ_DECODE = 2'd1,
    REQ_ALU_A  = 2'd2,
    REQ_ALU_B  = 2'd3
  } req_id_e;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regread_arbiter4_rr_pick4.sv
// Combinational round-robin picker: rotate the eligible vector so the pointer
// slot sits at bit 0, take the lowest set bit, then rotate the result back.
module rr_pick4
  import regread_arbiter4_pkg::*;
(
  input  logic [NREQ-1:0]  e,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output req_id_e          win_idx,
  output logic             valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   rot_oh;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    dbl     = {e, e};
    rot     = dbl[ptr +: NREQ];
    rot_oh  = rot & (~rot + NREQ'(1));
    // Index arithmetic wraps naturally in IDX_W bits, undoing the rotation.
    idx     = onehot2idx(rot_oh) + ptr;
    valid   = |e;
    win_idx = req_id_e'(idx);
    win_oh  = valid ? idx2onehot(idx) : '0;
  end

endmodule

// File: rtl/regread_arbiter4.sv
// Round-robin arbiter sharing one register-file read port among four requesters.
// Grant edge drives the mux select; the following edge captures data and acks.
module regread_arbiter4
  import regread_arbiter4_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic              stall,
  output logic [ADDR_W-1:0] s,
  input  logic [N-1:0]      rd,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [N-1:0]      dout,
  output logic              busy
);

  logic [IDX_W-1:0]  ptr;
  logic [NREQ-1:0]   pend;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   win_oh;
  req_id_e           win_idx;
  logic [IDX_W-1:0]  win_num;
  logic              win_valid;
  logic [ADDR_W-1:0] win_addr;

  assign elig    = req & ~pend & {NREQ{~stall}};
  assign win_num = win_idx;

  rr_pick4 u_pick (
    .e       (elig),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  always_comb begin
    win_addr = a0;
    case (win_idx)
      REQ_FETCH:  win_addr = a0;
      REQ_DECODE: win_addr = a1;
      REQ_ALU_A:  win_addr = a2;
      REQ_ALU_B:  win_addr = a3;
      default:    win_addr = a0;
    endcase
  end

  // Pending stays set from the grant edge through the ACK cycle so a held
  // request cannot be granted a second time for the same read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      pend <= '0;
      gnt  <= '0;
      s    <= '0;
      ack  <= '0;
      dout <= '0;
    end else begin
      gnt  <= win_oh;
      ack  <= gnt;
      pend <= (pend & ~ack) | win_oh;
      if (win_valid) begin
        s   <= win_addr;
        ptr <= win_num + IDX_W'(1);
      end
      if (|gnt) dout <= rd;
    end
  end

  assign busy = (|gnt) | (|ack);

endmodule

// File: doc/regread_arbiter4.md
# regread_arbiter4

Round-robin arbiter sharing one 32-entry register-file read path among four requesters (fetch, decode, ALU-A, ALU-B). Drives the 5-bit select of the external 32:1 N-bit read mux, captures the mux output one cycle later and returns it with a per-requester acknowledge. Pipelined: one grant per cycle, fixed two-cycle request-to-ACK latency.

## Interface

- N, default 8: data width of the register file and the read mux.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- REQ  in  4  per-requester read request; bit i is requester i.
- A0, A1, A2, A3  in  5 each  register address of requester i; sampled only in the cycle i wins.
- STALL  in  1  when high, no new grant is issued; in-flight reads complete.
- S  out  5  select to the shared 32:1 read mux (registered).
- RD  in  N  read mux output; combinational function of S.
- GNT  out  4  one-hot registered grant; high for exactly one cycle per grant.
- ACK  out  4  one-hot registered acknowledge; high for exactly one cycle, DOUT valid in that cycle.
- DOUT  out  N  read data for the requester acknowledged this cycle.
- BUSY  out  1  high while any read is granted or being acknowledged.

## Operation

- Eligible vector E = REQ & ~PEND & {4{~STALL}}.
- PEND[i] sets at the grant edge for i, clears at the edge ending i's ACK cycle; a requester is therefore never granted twice for one read.
- Winner: first set bit of E searching upward from PTR, wrapping 3 to 0. On a grant, PTR becomes winner+1 mod 4; with no grant, PTR holds.
- Grant edge: GNT becomes one-hot winner; S becomes A[winner]. With no winner, GNT becomes 0 and S holds its value.
- Capture edge (next edge): DOUT takes RD and ACK takes GNT. With GNT zero, ACK becomes 0 and DOUT holds.
- Protocol: a requester holds REQ and its address stable until ACK. It must drop REQ at the edge ending the ACK cycle; REQ still high after that edge is a new request.
- STALL is evaluated per cycle. It blocks only new grants; a grant issued before STALL still produces its ACK.
- BUSY = |GNT or |ACK.
- Reset: GNT=0, ACK=0, PEND=0, PTR=0, S=0, DOUT=0, BUSY=0. A reset asserted mid-read discards the in-flight read; no ACK is issued for it.

## Timing

- Request-to-ACK latency is 2 cycles: REQ high and winning in cycle t gives GNT in t+1 and ACK plus DOUT in t+2.
- Throughput is one grant per cycle across requesters. The same requester can be acknowledged at most once every 3 cycles (its REQ is eligible again in t+3).
- Simultaneous requests from all four with PTR=0 are granted in cycles t+1..t+4 in order 0,1,2,3, with ACKs in t+2..t+5.
- A grant and an ACK for different requesters may occur in the same cycle; GNT and ACK are independent one-hot vectors.
- The RD path is combinational from S inside one cycle; the block adds no combinational path from REQ or RD to any output.

## Structure

- Shared package holds NREQ=4, ADDR_W=5, and the one-hot/index conversion functions used by the arbiter and the decode stage.
- One sub-module: rr_pick4, a purely combinational rotate, priority-encode and unrotate block. Inputs are E and PTR; outputs are one-hot winner, winner index and valid.
- The top level holds the PTR, PEND, GNT, S, ACK and DOUT registers. The 32:1 mux stays outside this block and is instantiated next to the register file.

## Test plan

- Reset then single request: REQ=0001, A0=7, reg[7]=8'h5A gives GNT0 in t+1, S=7 in t+1, ACK0 with DOUT=5A in t+2, and BUSY high in t+1..t+2 only.
- All four requesting after reset with A0..A3=1,2,3,4 gives grants in order 0,1,2,3 on consecutive cycles and DOUT sequence reg[1..4] on consecutive ACKs.
- Fairness: with REQ0 and REQ1 held high and re-requesting after each ACK, grants alternate 0,1,0,1 with no starvation over 100 cycles.
- No double grant: REQ2 held high through its ACK cycle produces exactly one GNT2 before the ACK. A second GNT2 appears only in the cycle after the REQ2 edge that follows the ACK.
- STALL: STALL=1 in the cycle after GNT1 still gives ACK1 with correct data. No GNT while STALL=1; a pending REQ3 is granted in the first cycle after STALL drops.
- Reset mid-read: RST asserted in the GNT0 cycle gives no ACK0 afterwards and all outputs 0. After release, PTR=0 priority is restored (REQ=1001 grants 0 first).
